adc_frame_builder: RTL and testbench
====================================

// Module: adc_frame_builder
// PURPOSE
//  Downstream stage of the ADC sample buffer: wraps its byte stream into one framed AXI-Stream packet per burst.
//  Prepends a 6-byte header (magic, sequence number, payload length), passes PAYLOAD_BYTES payload bytes, drives tlast.
//  Pulses tx_done back to the buffer's read controller at frame end. Feeds the UDP/Ethernet TX path.
// PARAMETERS
//  MAGIC          16'hADC0  header word 0, sent MSB first
//  PAYLOAD_BYTES  1536      payload bytes per frame, 1..65535
// PORTS
//  clk            in   1   single clock for all logic (125 MHz dout domain)
//  rst            in   1   synchronous, active-high reset
//  hdr_req        in   1   buffer requests frame start (buffer's axis_tvalid_hdr); level, sampled in IDLE only
//  s_axis_tdata   in   8   payload byte from buffer
//  s_axis_tvalid  in   1   payload byte valid
//  s_axis_tlast   in   1   buffer's end-of-burst marker
//  s_axis_tready  out  1   payload accept (to buffer axis_tready)
//  m_axis_tdata   out  8   framed byte to TX path
//  m_axis_tvalid  out  1   framed byte valid
//  m_axis_tlast   out  1   last byte of frame
//  m_axis_tready  in   1   TX path ready
//  tx_done        out  1   one-cycle pulse after final frame byte is accepted
//  frame_seq      out  16  sequence number of the current/next frame
//  len_err        out  1   one-cycle pulse: s_axis_tlast did not coincide with byte PAYLOAD_BYTES-1
// BEHAVIOUR
//  Reset: state IDLE; s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; tx_done=0,
//   len_err=0, frame_seq=0, all counters 0. Reset mid-frame aborts the frame immediately; no tx_done.
//  Beat = cycle with tvalid & tready. m_axis_tvalid, once high, holds with stable tdata/tlast until its beat.
//  FSM:
//   IDLE: m_axis_tvalid=0, s_axis_tready=0. hdr_req=1 -> HDR next cycle, hdr_idx=0.
//   HDR : m_axis_tvalid=1; tdata by hdr_idx 0..5 = MAGIC[15:8], MAGIC[7:0], frame_seq[15:8],
//         frame_seq[7:0], PAYLOAD_BYTES[15:8], PAYLOAD_BYTES[7:0]. hdr_idx++ per m beat; beat at idx 5 -> PAY.
//         s_axis_tready=0 throughout.
//   PAY : combinational pass-through: m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid,
//         s_axis_tready=m_axis_tready. pay_cnt (16 b) ++ per beat. Frame ends on the beat where
//         pay_cnt==PAYLOAD_BYTES-1 OR s_axis_tlast=1, whichever first; m_axis_tlast=1 on that byte
//         (no FRAME_CSUM_EN) -> DONE, else -> CSUM.
//         len_err pulses the cycle after the ending beat if (pay_cnt==PAYLOAD_BYTES-1) != s_axis_tlast.
//         Early tlast: frame is short, header length unchanged. Late tlast: frame truncated at count;
//         surplus buffer bytes stay unconsumed for the next frame.
//   CSUM: (macro only) see CONFIGURATION. -> DONE after its last beat.
//   DONE: tx_done=1 for exactly this cycle; frame_seq++ (16-bit wrap FFFF->0000); -> IDLE.
//  Latency: first header byte valid 1 cycle after hdr_req seen in IDLE; payload adds 0 cycles.
//  hdr_req high in DONE/HDR/PAY/CSUM ignored; held high through DONE it starts the next frame from IDLE.
//  m_axis_tready low in any state stalls without byte loss or duplication.
// CONFIGURATION
//  FRAME_CSUM_EN defined: payload bytes summed (16-bit, modulo 2^16, reset to 0 in HDR) per payload beat;
//   CSUM state appends csum[15:8] then csum[7:0]; m_axis_tlast moves to csum[7:0]; frame = 6+N+2 bytes.
//  FRAME_CSUM_EN undefined: no CSUM state/adder; frame = 6+N bytes, tlast on last payload byte.
// TESTING
//  T1 PAYLOAD_BYTES=4, hdr_req, payload 01,02,03,04 (tlast on 04), tready=1 -> AD C0 00 00 00 04 01 02 03 04,
//     tlast on 04, tx_done 1 cycle after, frame_seq=1, no len_err.
//  T2 m_axis_tready toggled 1/0 every cycle across the T1 frame -> identical byte sequence, tvalid/tdata stable while stalled.
//  T3 s_axis_tlast on 2nd payload byte (PAYLOAD_BYTES=4) -> frame ends after 02 with tlast, len_err pulse, tx_done pulse.
//  T4 frame_seq preloaded to FFFF via 65535 frames (or force) -> header bytes FF FF, frame_seq becomes 0000 after tx_done.
//  T5 rst asserted during PAY byte 2 -> next cycle all outputs at reset values, no tx_done; next hdr_req yields clean frame, seq 0.
//  T6 FRAME_CSUM_EN, payload FF,FF,01,00 -> trailer 01 FF, tlast on FF trailer byte, frame length 12.

Source files
------------

// File: rtl/adc_frame_builder.sv
// Wraps the ADC buffer byte stream into framed AXI-Stream packets: 6-byte header, payload, tlast.
// Define FRAME_CSUM_EN to append a 16-bit modulo-2^16 payload checksum trailer (csum[15:8], csum[7:0]).
module adc_frame_builder #(
   parameter logic [15:0] MAGIC         = 16'hADC0,
   parameter int unsigned PAYLOAD_BYTES = 1536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hdr_req,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic        tx_done,
   output logic [15:0] frame_seq,
   output logic        len_err
);

   localparam logic [15:0] PAY_LEN  = 16'(PAYLOAD_BYTES);
   localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_BYTES - 1);

`ifdef FRAME_CSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAY,
      S_CSUM,
      S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_PAY,
      S_DONE
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [2:0]  hdr_idx_q, hdr_idx_d;
   logic [15:0] pay_cnt_q, pay_cnt_d;
   logic [15:0] frame_seq_q, frame_seq_d;
   logic        len_err_q, len_err_d;
`ifdef FRAME_CSUM_EN
   logic [15:0] csum_q, csum_d;
   logic        csum_idx_q, csum_idx_d;
`endif

   logic        pay_at_last;
   logic        pay_end;
   logic        m_beat;

   assign frame_seq = frame_seq_q;
   assign len_err   = len_err_q;

   always_comb begin
      state_d       = state_q;
      hdr_idx_d     = hdr_idx_q;
      pay_cnt_d     = pay_cnt_q;
      frame_seq_d   = frame_seq_q;
      len_err_d     = 1'b0;
`ifdef FRAME_CSUM_EN
      csum_d        = csum_q;
      csum_idx_d    = csum_idx_q;
`endif
      s_axis_tready = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      tx_done       = 1'b0;
      pay_at_last   = (pay_cnt_q == PAY_LAST);
      pay_end       = pay_at_last | s_axis_tlast;
      m_beat        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (hdr_req) begin
               state_d   = S_HDR;
               hdr_idx_d = '0;
            end
         end

         S_HDR: begin
            m_axis_tvalid = 1'b1;
            case (hdr_idx_q)
               3'd0:    m_axis_tdata = MAGIC[15:8];
               3'd1:    m_axis_tdata = MAGIC[7:0];
               3'd2:    m_axis_tdata = frame_seq_q[15:8];
               3'd3:    m_axis_tdata = frame_seq_q[7:0];
               3'd4:    m_axis_tdata = PAY_LEN[15:8];
               3'd5:    m_axis_tdata = PAY_LEN[7:0];
               default: m_axis_tdata = '0;
            endcase
            pay_cnt_d = '0;
`ifdef FRAME_CSUM_EN
            csum_d     = '0;
            csum_idx_d = 1'b0;
`endif
            if (m_axis_tready) begin
               if (hdr_idx_q == 3'd5) begin
                  state_d = S_PAY;
               end else begin
                  hdr_idx_d = hdr_idx_q + 3'd1;
               end
            end
         end

         S_PAY: begin
            // Straight pass-through: the buffer sees the TX path's backpressure directly.
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            m_beat        = s_axis_tvalid & m_axis_tready;
`ifdef FRAME_CSUM_EN
            m_axis_tlast  = 1'b0;
`else
            m_axis_tlast  = s_axis_tvalid & pay_end;
`endif
            if (m_beat) begin
               pay_cnt_d = pay_cnt_q + 16'd1;
`ifdef FRAME_CSUM_EN
               csum_d    = csum_q + {8'd0, s_axis_tdata};
`endif
               if (pay_end) begin
                  len_err_d = (pay_at_last != s_axis_tlast);
`ifdef FRAME_CSUM_EN
                  state_d   = S_CSUM;
`else
                  state_d   = S_DONE;
`endif
               end
            end
         end

`ifdef FRAME_CSUM_EN
         S_CSUM: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = csum_idx_q ? csum_q[7:0] : csum_q[15:8];
            m_axis_tlast  = csum_idx_q;
            if (m_axis_tready) begin
               if (csum_idx_q) begin
                  state_d = S_DONE;
               end else begin
                  csum_idx_d = 1'b1;
               end
            end
         end
`endif

         S_DONE: begin
            tx_done     = 1'b1;
            frame_seq_d = frame_seq_q + 16'd1;
            state_d     = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hdr_idx_q   <= '0;
         pay_cnt_q   <= '0;
         frame_seq_q <= '0;
         len_err_q   <= 1'b0;
`ifdef FRAME_CSUM_EN
         csum_q      <= '0;
         csum_idx_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hdr_idx_q   <= hdr_idx_d;
         pay_cnt_q   <= pay_cnt_d;
         frame_seq_q <= frame_seq_d;
         len_err_q   <= len_err_d;
`ifdef FRAME_CSUM_EN
         csum_q      <= csum_d;
         csum_idx_q  <= csum_idx_d;
`endif
      end
   end

endmodule

// File: tb/tb_adc_frame_builder.sv
// Self-checking bench for adc_frame_builder (PAYLOAD_BYTES=4); expected bytes flow through a scoreboard queue.
module tb_adc_frame_builder;

   localparam logic [15:0] TB_MAGIC = 16'hADC0;
   localparam int          PB       = 4;
   localparam logic [15:0] PB16     = 16'(PB);
`ifdef FRAME_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hdr_req;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready;
   logic        tx_done;
   logic [15:0] frame_seq;
   logic        len_err;

   adc_frame_builder #(.MAGIC(TB_MAGIC), .PAYLOAD_BYTES(PB)) dut (
      .clk           (clk),
      .rst           (rst),
      .hdr_req       (hdr_req),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .tx_done       (tx_done),
      .frame_seq     (frame_seq),
      .len_err       (len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       end_pay;
      logic       lerr;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      int          tlast_at;
      int          mode;
      int          exp_len;
      bit          exp_lerr;
   } vec_t;

   exp_t        exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          beats = 0;
   int          ready_mode = 0;
   logic [15:0] exp_seq = '0;

   logic        exp_done_n, exp_lerr_n;
   logic        stalled_prev;
   logic [7:0]  prev_data;
   logic        prev_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // TX-side ready pattern: 0 always ready, 1 toggling, 2 random.
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_done_n   = 1'b0;
         exp_lerr_n   = 1'b0;
         stalled_prev = 1'b0;
      end else begin
         chk("tx_done", 32'(tx_done), 32'(exp_done_n));
         chk("len_err", 32'(len_err), 32'(exp_lerr_n));
         exp_done_n = 1'b0;
         exp_lerr_n = 1'b0;
         if (stalled_prev) begin
            chk("stall_tvalid", 32'(m_tvalid), 32'd1);
            chk("stall_tdata", 32'(m_tdata), 32'(prev_data));
            chk("stall_tlast", 32'(m_tlast), 32'(prev_last));
         end
         if (m_tvalid && m_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
            end else begin
               exp_t it;
               it = exp_q.pop_front();
               chk("m_tdata", 32'(m_tdata), 32'(it.data));
               chk("m_tlast", 32'(m_tlast), 32'(it.last));
               exp_done_n = it.last;
               exp_lerr_n = it.end_pay & it.lerr;
            end
         end
         stalled_prev = m_tvalid && !m_tready;
         prev_data    = m_tdata;
         prev_last    = m_tlast;
      end
   end

   task automatic push_hdr();
      exp_q.push_back('{TB_MAGIC[15:8], 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{TB_MAGIC[7:0], 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{exp_seq[15:8], 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{exp_seq[7:0], 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{PB16[15:8], 1'b0, 1'b0, 1'b0});
      exp_q.push_back('{PB16[7:0], 1'b0, 1'b0, 1'b0});
   endtask

   task automatic run_frame(input logic [31:0] d, input int tlast_at, input int mode,
                            input int exp_len, input bit exp_lerr);
      logic [15:0] sum;
      int          g;
      sum = '0;
      ready_mode = mode;
      push_hdr();
      for (int i = 0; i < exp_len; i++) begin
         exp_q.push_back('{d[8*i +: 8], !CSUM && (i == exp_len - 1), i == exp_len - 1, exp_lerr});
         sum = sum + {8'd0, d[8*i +: 8]};
      end
      if (CSUM) begin
         exp_q.push_back('{sum[15:8], 1'b0, 1'b0, 1'b0});
         exp_q.push_back('{sum[7:0], 1'b1, 1'b0, 1'b0});
      end

      @(posedge clk); #1;
      hdr_req = 1'b1;
      @(negedge clk);
      chk("hdr_lat_idle", 32'(m_tvalid), 32'd0);
      @(negedge clk);
      chk("hdr_lat_first", 32'(m_tvalid), 32'd1);
      @(posedge clk); #1;
      hdr_req = 1'b0;

      for (int i = 0; i < exp_len; i++) begin
         s_tdata  = d[8*i +: 8];
         s_tvalid = 1'b1;
         s_tlast  = (i == tlast_at);
         g = 0;
         forever begin
            @(negedge clk);
            if (s_tready) break;
            g++;
            if (g > 200) begin
               chk("s_accept_timeout", 32'd0, 32'd1);
               break;
            end
         end
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;

      g = 0;
      while (!tx_done && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (!tx_done) chk("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      exp_seq = exp_seq + 16'd1;
      chk("frame_seq", 32'(frame_seq), 32'(exp_seq));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[6];
      int   g;
      vecs[0] = '{32'h04030201, 3, 0, 4, 1'b0};  // nominal frame
      vecs[1] = '{32'h04030201, 3, 1, 4, 1'b0};  // toggling backpressure
      vecs[2] = '{32'h04030201, 1, 0, 2, 1'b1};  // early tlast
      vecs[3] = '{32'h0001FFFF, 3, 2, 4, 1'b0};  // random backpressure, checksum pattern
      vecs[4] = '{32'h80005AA5, 7, 1, 4, 1'b1};  // no tlast: truncated at count
      vecs[5] = '{32'h1122333C, 0, 0, 1, 1'b1};  // tlast on first payload byte

      rst = 1'b1; hdr_req = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tdata", 32'(m_tdata), 32'd0);
      chk("rst_m_tlast", 32'(m_tlast), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_tx_done", 32'(tx_done), 32'd0);
      chk("rst_len_err", 32'(len_err), 32'd0);
      chk("rst_frame_seq", 32'(frame_seq), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v].d, vecs[v].tlast_at, vecs[v].mode, vecs[v].exp_len, vecs[v].exp_lerr);
      end

      // Reset while the second payload byte is on the bus: frame aborted, no tx_done.
      ready_mode = 0;
      push_hdr();
      exp_q.push_back('{8'h77, 1'b0, 1'b0, 1'b0});
      @(posedge clk); #1;
      hdr_req  = 1'b1;
      s_tdata  = 8'h77;
      s_tvalid = 1'b1;
      s_tlast  = 1'b0;
      beats    = 0;
      g = 0;
      while (beats < 7 && g < 100) begin
         @(posedge clk); #1;
         hdr_req = 1'b0;
         g++;
      end
      chk("abort_reach_pay", 32'(beats), 32'd7);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_queue", 32'(exp_q.size()), 32'd0);
      chk("abort_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("abort_m_tdata", 32'(m_tdata), 32'd0);
      chk("abort_m_tlast", 32'(m_tlast), 32'd0);
      chk("abort_s_tready", 32'(s_tready), 32'd0);
      chk("abort_tx_done", 32'(tx_done), 32'd0);
      chk("abort_len_err", 32'(len_err), 32'd0);
      chk("abort_frame_seq", 32'(frame_seq), 32'd0);
      exp_q.delete();
      s_tvalid = 1'b0;
      rst = 1'b0;
      exp_seq = '0;
      run_frame(32'h04030201, 3, 0, 4, 1'b0);

      // Sequence number wrap FFFF -> 0000.
      @(posedge clk); #1;
      force dut.frame_seq_q = 16'hFFFF;
      @(posedge clk); #1;
      release dut.frame_seq_q;
      @(posedge clk); #1;
      chk("seq_preload", 32'(frame_seq), 32'h0000_FFFF);
      exp_seq = 16'hFFFF;
      run_frame(32'h04030201, 3, 1, 4, 1'b0);
      chk("seq_wrapped", 32'(frame_seq), 32'd0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
